// File: rtl/gpio_regs_if.sv
// picorv32 native memory bus as seen by a memory-mapped peripheral.
// hit is driven by the peripheral so the SOC can steer the response mux.
interface gpio_regs_if;
   logic        mem_valid;
   logic        mem_instr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        hit;

   modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                   input  mem_rdata, mem_ready, hit);
   modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                   output mem_rdata, mem_ready, hit);
endinterface

// File: rtl/gpio_regs.sv
// GPIO pad-control register block: byte-strobed RW registers, synchronized
// inputs, W1C rising-edge latch and a level interrupt.
module gpio_regs #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int          ADDR_W    = 12
) (
   input  logic        clk,
   input  logic        rstn,
   gpio_regs_if.slave  bus,
   input  logic [31:0] gpio_di,
   output logic [31:0] gpio_do,
   output logic [31:0] gpio_oe,
   output logic [31:0] gpio_ps,
   output logic [31:0] gpio_is,
   output logic [31:0] gpio_ds0,
   output logic [31:0] gpio_ds1,
   output logic [31:0] gpio_sr,
   output logic        irq
);
   localparam int OW  = ADDR_W - 2;
   localparam int NRW = 7;
   localparam logic [OW-1:0] OFF_DI   = OW'(7);
   localparam logic [OW-1:0] OFF_EDGE = OW'(8);
   localparam logic [OW-1:0] OFF_IEN  = OW'(9);

   typedef enum logic {IDLE, RESP} state_t;

   state_t              state;
   logic [NRW-1:0][31:0] rw_q;
   logic [31:0]         irq_en, edge_q, sync1, sync2, prev;
   logic [31:0]         mask, merged, rd, clr, rise, edge_nxt, irq_en_nxt;
   logic [OW-1:0]       off;
   logic                acc, we;

   assign bus.hit = bus.mem_valid && (bus.mem_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
   assign off     = bus.mem_addr[ADDR_W-1:2];
   assign acc     = bus.hit && (state == IDLE);
   assign we      = acc && (|bus.mem_wstrb) && !bus.mem_instr;
   assign mask    = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                     {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};

   always_comb begin
      rd = '0;
      case (off)
         OW'(0):   rd = rw_q[0];
         OW'(1):   rd = rw_q[1];
         OW'(2):   rd = rw_q[2];
         OW'(3):   rd = rw_q[3];
         OW'(4):   rd = rw_q[4];
         OW'(5):   rd = rw_q[5];
         OW'(6):   rd = rw_q[6];
         OFF_DI:   rd = sync2;
         OFF_EDGE: rd = edge_q;
         OFF_IEN:  rd = irq_en;
         default:  rd = '0;
      endcase
   end

   // Set dominates clear so a rise landing on a W1C write is never lost.
   always_comb begin
      merged     = '0;
      clr        = '0;
      irq_en_nxt = irq_en;
      if (we && off == OFF_EDGE) clr = bus.mem_wdata & mask;
      if (we && off == OFF_IEN) begin
         merged     = (irq_en & ~mask) | (bus.mem_wdata & mask);
         irq_en_nxt = merged;
      end
      rise     = sync2 & ~prev;
      edge_nxt = (edge_q & ~clr) | rise;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= IDLE;
         bus.mem_ready <= 1'b0;
         bus.mem_rdata <= '0;
         rw_q          <= '0;
         irq_en        <= '0;
         edge_q        <= '0;
         sync1         <= '0;
         sync2         <= '0;
         prev          <= '0;
         irq           <= 1'b0;
      end else begin
         sync1  <= gpio_di;
         sync2  <= sync1;
         prev   <= sync2;
         edge_q <= edge_nxt;
         irq_en <= irq_en_nxt;
         irq    <= |(edge_nxt & irq_en_nxt);
         for (int i = 0; i < NRW; i++)
            if (we && off == OW'(i)) rw_q[i] <= (rw_q[i] & ~mask) | (bus.mem_wdata & mask);
         case (state)
            IDLE: if (acc) begin
               state         <= RESP;
               bus.mem_ready <= 1'b1;
               bus.mem_rdata <= we ? 32'h0 : rd;
            end
            RESP: begin
               state         <= IDLE;
               bus.mem_ready <= 1'b0;
               bus.mem_rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign gpio_do  = rw_q[0];
   assign gpio_oe  = rw_q[1];
   assign gpio_ps  = rw_q[2];
   assign gpio_is  = rw_q[3];
   assign gpio_ds0 = rw_q[4];
   assign gpio_ds1 = rw_q[5];
   assign gpio_sr  = rw_q[6];
endmodule
